// File: rtl/pwm_duty_ramp_if.sv
// Switch/duty bundle between the PWM duty control stage and its neighbours.
interface pwm_duty_ramp_if;
    logic [3:0] sw_raw;
    logic       period_end;
    logic [3:0] duty_code;
    logic [3:0] target;
    logic       duty_update;
    logic       busy;

    modport master (
        output sw_raw, period_end,
        input  duty_code, target, duty_update, busy
    );

    modport slave (
        input  sw_raw, period_end,
        output duty_code, target, duty_update, busy
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Duty-code control for the PWM stage: sync + debounce of sw_raw, then duty steps on
// period boundaries. PWM_RAMP_EN defined: slew one step per RAMP_PERIODS; else jump.
module pwm_duty_ramp #(
    parameter int DB_CYCLES    = 1000,
    parameter int RAMP_PERIODS = 4
) (
    input  logic           clk,
    input  logic           rst,
    pwm_duty_ramp_if.slave bus
);
    localparam int DBW = $clog2(DB_CYCLES);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || RAMP_PERIODS < 1) begin : g_param_check
        $error("pwm_duty_ramp: need DB_CYCLES >= 2 and RAMP_PERIODS >= 1");
    end

    typedef enum logic {IDLE, WAIT} state_t;

    logic [3:0]     sw_m, sw_s, candidate, target_q;
    logic [DBW-1:0] db_cnt;
    logic [3:0]     duty_q, duty_n;
    logic           upd_q, upd_n;
    state_t         state, state_n;

    // Target is loaded on the edge the counter reaches DB_MAX and kept loaded while saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m      <= '0;
            sw_s      <= '0;
            candidate <= '0;
            db_cnt    <= '0;
            target_q  <= '0;
        end else begin
            sw_m <= bus.sw_raw;
            sw_s <= sw_m;
            if (sw_s != candidate) begin
                candidate <= sw_s;
                db_cnt    <= '0;
            end else begin
                if (db_cnt != DB_MAX) db_cnt <= db_cnt + 1'b1;
                if (db_cnt >= DB_MAX - 1'b1) target_q <= candidate;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            duty_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            state  <= state_n;
            duty_q <= duty_n;
            upd_q  <= upd_n;
        end
    end

`ifdef PWM_RAMP_EN
    localparam int PW = $clog2(RAMP_PERIODS) + 1;
    localparam logic [PW-1:0] P_LAST = PW'(RAMP_PERIODS - 1);

    logic [PW-1:0] pcnt, pcnt_n;
    logic [3:0]    step_val;

    // Direction comes from the current target, so a reversal takes effect at the next step.
    assign step_val = (target_q > duty_q) ? duty_q + 4'd1 : duty_q - 4'd1;

    always_ff @(posedge clk) begin
        if (rst) pcnt <= '0;
        else     pcnt <= pcnt_n;
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        duty_n  = duty_q;
        upd_n   = 1'b0;
        case (state)
            IDLE: begin
                pcnt_n = '0;
                if (target_q != duty_q) state_n = WAIT;
            end
            WAIT: begin
                if (target_q == duty_q) begin
                    state_n = IDLE;
                    pcnt_n  = '0;
                end else if (bus.period_end) begin
                    if (pcnt == P_LAST) begin
                        duty_n = step_val;
                        upd_n  = 1'b1;
                        pcnt_n = '0;
                        if (step_val == target_q) state_n = IDLE;
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
`else
    always_comb begin
        state_n = state;
        duty_n  = duty_q;
        upd_n   = 1'b0;
        case (state)
            IDLE: if (target_q != duty_q) state_n = WAIT;
            WAIT: begin
                if (target_q == duty_q) begin
                    state_n = IDLE;
                end else if (bus.period_end) begin
                    duty_n  = target_q;
                    upd_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
`endif

    assign bus.duty_code   = duty_q;
    assign bus.target      = target_q;
    assign bus.duty_update = upd_q;
    assign bus.busy        = (target_q != duty_q);
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed scenarios plus randomized switch/period traffic
// checked against a behavioural model (window-based debounce, period-count stepping).
module tb_pwm_duty_ramp;
    localparam int DB = 16;
    localparam int RP = 2;
`ifdef PWM_RAMP_EN
    localparam int STEP_P = RP;
`else
    localparam int STEP_P = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pe_auto = 1'b0, pe_gen = 1'b0, pe_man = 1'b0;
    int   pe_lo = 16, pe_hi = 16, pe_cnt = 0;
    int   total = 0, bad = 0;

    pwm_duty_ramp_if bus();
    assign bus.period_end = pe_auto ? pe_gen : pe_man;

    pwm_duty_ramp #(.DB_CYCLES(DB), .RAMP_PERIODS(RP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Free-running period_end source: single-cycle pulse every pe_lo..pe_hi cycles.
    always @(negedge clk) begin
        if (!pe_auto) begin
            pe_gen = 1'b0;
            pe_cnt = pe_lo - 1;
        end else if (pe_cnt == 0) begin
            pe_gen = 1'b1;
            pe_cnt = $urandom_range(pe_hi, pe_lo) - 1;
        end else begin
            pe_gen = 1'b0;
            pe_cnt = pe_cnt - 1;
        end
    end

    // Reference model: target follows any value held for DB consecutive synchronised
    // samples; duty moves after STEP_P periods spent fully inside a busy interval.
    logic [3:0] hq[$];
    logic [3:0] m_target = '0, m_duty = '0, t_old, d_old;
    logic       m_upd = 1'b0, m_busy_prev = 1'b0, m_busy, m_eq;
    int         m_per = 0;

    always @(posedge clk) begin
        t_old = m_target;
        d_old = m_duty;
        hq.push_back(rst ? 4'h0 : bus.sw_raw);
        if (hq.size() > DB + 2) void'(hq.pop_front());
        if (rst) begin
            m_target = '0; m_duty = '0; m_upd = 1'b0; m_per = 0; m_busy_prev = 1'b0;
        end else begin
            m_busy = (t_old != d_old);
            m_upd  = 1'b0;
            if (!m_busy) m_per = 0;
            else if (bus.period_end && m_busy_prev) begin
                m_per++;
                if (m_per == STEP_P) begin
                    m_per = 0;
                    m_upd = 1'b1;
`ifdef PWM_RAMP_EN
                    m_duty = (t_old > d_old) ? d_old + 4'd1 : d_old - 4'd1;
`else
                    m_duty = t_old;
`endif
                end
            end
            m_busy_prev = m_busy;
            if (hq.size() == DB + 2) begin
                m_eq = 1'b1;
                for (int i = 1; i < DB; i++) if (hq[i] != hq[0]) m_eq = 1'b0;
                if (m_eq) m_target = hq[0];
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse();
        pe_man = 1'b1;
        @(negedge clk);
        pe_man = 1'b0;
    endtask

    task automatic test_reset();
        bus.sw_raw = 4'hF;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({bus.duty_code, bus.target, bus.duty_update, bus.busy} !== 10'd0) begin
                bad++;
                $display("FAIL reset_outs cyc=%0d got duty=%h tgt=%h upd=%b busy=%b want all 0",
                         c, bus.duty_code, bus.target, bus.duty_update, bus.busy);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) begin
                total++;
                if (bus.target !== 4'h0) begin
                    bad++; $display("FAIL reset_early_tgt got=%h want=0", bus.target);
                end
            end
            if (k == 18) begin
                total++;
                if (bus.target !== 4'hF) begin
                    bad++; $display("FAIL reset_tgt_18 got=%h want=F", bus.target);
                end
                total++;
                if (bus.busy !== 1'b1) begin
                    bad++; $display("FAIL reset_busy got=%b want=1", bus.busy);
                end
            end
        end
    endtask

    task automatic test_bounce();
        bus.sw_raw = 4'hE;
        repeat (25) @(negedge clk);
        total++;
        if (bus.target !== 4'hE) begin
            bad++; $display("FAIL bounce_pre got=%h want=E", bus.target);
        end
        for (int c = 0; c < 60; c++) begin
            if (c % 10 == 0) bus.sw_raw[0] = ~bus.sw_raw[0];
            @(negedge clk);
            total++;
            if (bus.target !== 4'hE) begin
                bad++; $display("FAIL bounce_hold cyc=%0d got=%h want=E", c, bus.target);
            end
        end
        bus.sw_raw = 4'hF;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) begin
                total++;
                if (bus.target !== 4'hE) begin
                    bad++; $display("FAIL bounce_early got=%h want=E", bus.target);
                end
            end
            if (k == 18) begin
                total++;
                if (bus.target[0] !== 1'b1) begin
                    bad++; $display("FAIL bounce_settle got=%h want=F", bus.target);
                end
            end
        end
    endtask

`ifdef PWM_RAMP_EN
    task automatic test_ramp_up();
        int ups, e_duty;
        pe_auto = 1'b0;
        bus.sw_raw = 4'h0;
        do_reset(2);
        bus.sw_raw = 4'h3;
        repeat (20) @(negedge clk);
        ups = 0;
        for (int p = 1; p <= 8; p++) begin
            for (int c = 0; c < 31; c++) begin
                @(negedge clk);
                if (bus.duty_update) ups++;
            end
            pulse();
            if (bus.duty_update) ups++;
            e_duty = (p / 2 > 3) ? 3 : p / 2;
            total++;
            if (bus.duty_code !== 4'(e_duty)) begin
                bad++; $display("FAIL ramp_duty pe=%0d got=%h want=%h", p, bus.duty_code, e_duty);
            end
            total++;
            if (bus.duty_update !== (p % 2 == 0 && p <= 6)) begin
                bad++; $display("FAIL ramp_upd pe=%0d got=%b", p, bus.duty_update);
            end
            total++;
            if (bus.busy !== (p < 6)) begin
                bad++; $display("FAIL ramp_busy pe=%0d got=%b want=%b", p, bus.busy, p < 6);
            end
        end
        total++;
        if (ups != 3) begin
            bad++; $display("FAIL ramp_upd_count got=%0d want=3", ups);
        end
    endtask

    task automatic test_reversal();
        logic [3:0] exp_seq[3];
        int got, n, extra;
        exp_seq = '{4'd4, 4'd3, 4'd2};
        pe_auto = 1'b0;
        bus.sw_raw = 4'h0;
        do_reset(2);
        pe_lo = 16; pe_hi = 16; pe_auto = 1'b1;
        bus.sw_raw = 4'h8;
        n = 0;
        while (bus.duty_code !== 4'd5 && n < 2000) begin
            @(negedge clk); n++;
        end
        total++;
        if (bus.duty_code !== 4'd5) begin
            bad++; $display("FAIL rev_reach5 timeout got=%h want=5", bus.duty_code);
        end
        bus.sw_raw = 4'h2;
        got = 0; n = 0;
        while (got < 3 && n < 1000) begin
            @(negedge clk); n++;
            if (bus.duty_update) begin
                total++;
                if (bus.duty_code !== exp_seq[got]) begin
                    bad++; $display("FAIL rev_step%0d got=%h want=%h", got, bus.duty_code, exp_seq[got]);
                end
                got++;
            end
        end
        total++;
        if (got != 3) begin
            bad++; $display("FAIL rev_timeout steps=%0d want=3", got);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL rev_busy got=%b want=0", bus.busy);
        end
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.duty_update) extra++;
        end
        total++;
        if (extra != 0 || bus.duty_code !== 4'd2) begin
            bad++; $display("FAIL rev_idle extra=%0d duty=%h want 0 and 2", extra, bus.duty_code);
        end
        pe_auto = 1'b0;
    endtask

    task automatic test_coincident();
        pe_auto = 1'b0;
        bus.sw_raw = 4'h5;
        do_reset(2);
        repeat (20) @(negedge clk);
        repeat (10) begin
            pulse();
            repeat (3) @(negedge clk);
        end
        total++;
        if (bus.duty_code !== 4'd5 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL coin_setup duty=%h busy=%b want 5,0", bus.duty_code, bus.busy);
        end
        bus.sw_raw = 4'h6;
        repeat (20) @(negedge clk);
        pulse();
        repeat (3) @(negedge clk);
        total++;
        if (bus.duty_code !== 4'd5) begin
            bad++; $display("FAIL coin_half got=%h want=5", bus.duty_code);
        end
        bus.sw_raw = 4'h4;
        repeat (17) @(negedge clk);
        pulse();
        total++;
        if (bus.duty_code !== 4'd6 || bus.duty_update !== 1'b1) begin
            bad++; $display("FAIL coin_step got duty=%h upd=%b want 6,1", bus.duty_code, bus.duty_update);
        end
        total++;
        if (bus.target !== 4'h4) begin
            bad++; $display("FAIL coin_tgt got=%h want=4", bus.target);
        end
        repeat (3) @(negedge clk);
        pulse();
        total++;
        if (bus.duty_code !== 4'd6) begin
            bad++; $display("FAIL coin_wait got=%h want=6", bus.duty_code);
        end
        repeat (3) @(negedge clk);
        pulse();
        total++;
        if (bus.duty_code !== 4'd5 || bus.duty_update !== 1'b1) begin
            bad++; $display("FAIL coin_back got duty=%h upd=%b want 5,1", bus.duty_code, bus.duty_update);
        end
    endtask
`else
    task automatic test_bypass();
        int ups;
        pe_auto = 1'b0;
        bus.sw_raw = 4'h0;
        do_reset(2);
        bus.sw_raw = 4'hC;
        repeat (20) @(negedge clk);
        total++;
        if (bus.target !== 4'hC || bus.duty_code !== 4'h0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL byp_pre tgt=%h duty=%h busy=%b want C,0,1",
                            bus.target, bus.duty_code, bus.busy);
        end
        pulse();
        total++;
        if (bus.duty_code !== 4'hC || bus.duty_update !== 1'b1) begin
            bad++; $display("FAIL byp_jump duty=%h upd=%b want C,1", bus.duty_code, bus.duty_update);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL byp_busy got=%b want=0", bus.busy);
        end
        ups = 0;
        repeat (3) begin
            repeat (5) begin
                @(negedge clk);
                if (bus.duty_update) ups++;
            end
            pulse();
            if (bus.duty_update) ups++;
        end
        total++;
        if (ups != 0 || bus.duty_code !== 4'hC) begin
            bad++; $display("FAIL byp_single extra=%0d duty=%h want 0,C", ups, bus.duty_code);
        end
    endtask
`endif

    task automatic test_random();
        int hold;
        bus.sw_raw = 4'h0;
        pe_auto = 1'b0;
        do_reset(2);
        pe_lo = 8; pe_hi = 40; pe_auto = 1'b1;
        for (int s = 0; s < 40; s++) begin
            bus.sw_raw = 4'($urandom_range(15, 0));
            hold = ($urandom_range(1, 0) == 1) ? $urandom_range(12, 1) : $urandom_range(150, 20);
            if (s == 20) do_reset(2);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                total++;
                if (bus.target !== m_target) begin
                    bad++; $display("FAIL rnd_tgt seg=%0d got=%h want=%h", s, bus.target, m_target);
                end
                total++;
                if (bus.duty_code !== m_duty) begin
                    bad++; $display("FAIL rnd_duty seg=%0d got=%h want=%h", s, bus.duty_code, m_duty);
                end
                total++;
                if (bus.duty_update !== m_upd) begin
                    bad++; $display("FAIL rnd_upd seg=%0d got=%b want=%b", s, bus.duty_update, m_upd);
                end
                total++;
                if (bus.busy !== (m_target != m_duty)) begin
                    bad++; $display("FAIL rnd_busy seg=%0d got=%b want=%b", s, bus.busy, m_target != m_duty);
                end
            end
        end
        pe_auto = 1'b0;
    endtask

    initial begin
        bus.sw_raw = 4'hF;
        test_reset();
        test_bounce();
`ifdef PWM_RAMP_EN
        test_ramp_up();
        test_reversal();
        test_coincident();
`else
        test_bypass();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
